vscale_imem_fetch_unit: RTL and testbench

Instruction-fetch front end that sits between the PC mux and instruction memory. It holds the architectural fetch PC (`PC_IF`) and loads the mux's next-PC (`PC_PIF`) on every accepted request or redirect. It issues pipelined, in-order requests over a valid/ready request channel and a valid-only response channel. It buffers returned instructions with their PCs for the DX stage and discards responses belonging to requests killed by a redirect.

---
 rtl/vscale_imem_fetch_unit_if.sv | 31 +++
 rtl/vscale_imem_fetch_unit.sv | 139 +++++++++++++
 tb/tb_vscale_imem_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vscale_imem_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave):
// a valid/ready request channel and an in-order, valid-only response channel.
interface vscale_imem_fetch_unit_if #(
    parameter int XPR_LEN    = 32,
    parameter int INST_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [XPR_LEN-1:0]    req_addr;
    logic                  resp_valid;
    logic [INST_WIDTH-1:0] resp_data;
    logic                  resp_err;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_err
    );
endinterface

// File: rtl/vscale_imem_fetch_unit.sv
// Fetch front end: owns PC_IF, issues pipelined in-order imem requests, buffers returned
// instructions with their PCs for DX, and drops responses belonging to redirected-away fetches.
module vscale_imem_fetch_unit #(
    parameter int                 XPR_LEN    = 32,
    parameter int                 INST_WIDTH = 32,
    parameter logic [XPR_LEN-1:0] RESET_PC   = 32'h200,
    parameter int                 DEPTH      = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [XPR_LEN-1:0]       PC_PIF,
    input  logic                     redirect,
    output logic [XPR_LEN-1:0]       PC_IF,
    vscale_imem_fetch_unit_if.master imem,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [INST_WIDTH-1:0]    inst_DX,
    output logic [XPR_LEN-1:0]       inst_PC,
    output logic                     inst_fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam int OW = AW + 2;
    localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

    logic [XPR_LEN-1:0] pc_if_reg, pc_if_next;
    logic [PW-1:0]      pc_wr_ptr_reg, pc_wr_ptr_next;
    logic [PW-1:0]      pc_rd_ptr_reg, pc_rd_ptr_next;
    logic [PW-1:0]      inst_wr_ptr_reg, inst_wr_ptr_next;
    logic [PW-1:0]      inst_rd_ptr_reg, inst_rd_ptr_next;
    logic [PW-1:0]      kill_cnt_reg, kill_cnt_next;

    logic [XPR_LEN-1:0]    pc_mem        [DEPTH];
    logic [INST_WIDTH-1:0] inst_data_mem [DEPTH];
    logic [XPR_LEN-1:0]    inst_pc_mem   [DEPTH];
    logic                  inst_fault_mem[DEPTH];

    logic [PW-1:0]      pc_count;
    logic [PW-1:0]      inst_count;
    logic [OW-1:0]      occupancy;
    logic               pc_fifo_empty;
    logic               req_fire;
    logic               resp_fire;
    logic               resp_keep;
    logic               inst_pop;
    logic [XPR_LEN-1:0] pc_head;

    assign pc_count      = pc_wr_ptr_reg - pc_rd_ptr_reg;
    assign inst_count    = inst_wr_ptr_reg - inst_rd_ptr_reg;
    assign pc_fifo_empty = (pc_wr_ptr_reg == pc_rd_ptr_reg);
    assign pc_head       = pc_mem[pc_rd_ptr_reg[AW-1:0]];

    assign inst_valid = (inst_count != '0);
    assign inst_pop   = inst_valid & inst_ready & ~redirect;

    // The slot freed by this cycle's DX pop is counted as available; without that the
    // steady state (one in flight, one buffered) would stall every other cycle.
    assign occupancy = {1'b0, pc_count} + {1'b0, inst_count} - {{(OW-1){1'b0}}, inst_pop};

    assign imem.req_valid = reset_n & (occupancy < DEPTH_W) & ~redirect;
    assign imem.req_addr  = pc_if_reg;
    assign PC_IF          = pc_if_reg;

    assign req_fire  = imem.req_valid & imem.req_ready;
    assign resp_fire = imem.resp_valid & ~pc_fifo_empty;
    assign resp_keep = resp_fire & (kill_cnt_reg == '0) & ~redirect;

    always_comb begin
        pc_if_next       = pc_if_reg;
        pc_wr_ptr_next   = pc_wr_ptr_reg + PW'(req_fire);
        pc_rd_ptr_next   = pc_rd_ptr_reg + PW'(resp_fire);
        inst_wr_ptr_next = inst_wr_ptr_reg + PW'(resp_keep);
        inst_rd_ptr_next = inst_rd_ptr_reg + PW'(inst_pop);
        kill_cnt_next    = kill_cnt_reg;

        if (redirect || req_fire) begin
            pc_if_next = PC_PIF;
        end

        if (redirect) begin
            inst_rd_ptr_next = inst_wr_ptr_reg;
            // Everything still in flight is stale; a response landing now is one of them.
            kill_cnt_next    = pc_count - PW'(resp_fire);
        end else if (resp_fire && (kill_cnt_reg != '0)) begin
            kill_cnt_next = kill_cnt_reg - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_if_reg       <= RESET_PC;
            pc_wr_ptr_reg   <= '0;
            pc_rd_ptr_reg   <= '0;
            inst_wr_ptr_reg <= '0;
            inst_rd_ptr_reg <= '0;
            kill_cnt_reg    <= '0;
        end else begin
            pc_if_reg       <= pc_if_next;
            pc_wr_ptr_reg   <= pc_wr_ptr_next;
            pc_rd_ptr_reg   <= pc_rd_ptr_next;
            inst_wr_ptr_reg <= inst_wr_ptr_next;
            inst_rd_ptr_reg <= inst_rd_ptr_next;
            kill_cnt_reg    <= kill_cnt_next;
        end
    end

    // Entries are reset so the head outputs read zero straight out of reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pc_mem[gi]         <= '0;
                    inst_data_mem[gi]  <= '0;
                    inst_pc_mem[gi]    <= '0;
                    inst_fault_mem[gi] <= 1'b0;
                end else begin
                    if (req_fire && (pc_wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                        pc_mem[gi] <= pc_if_reg;
                    end
                    if (resp_keep && (inst_wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                        inst_data_mem[gi]  <= imem.resp_data;
                        inst_pc_mem[gi]    <= pc_head;
                        inst_fault_mem[gi] <= imem.resp_err;
                    end
                end
            end
        end
    endgenerate

    assign inst_DX    = inst_data_mem[inst_rd_ptr_reg[AW-1:0]];
    assign inst_PC    = inst_pc_mem[inst_rd_ptr_reg[AW-1:0]];
    assign inst_fault = inst_fault_mem[inst_rd_ptr_reg[AW-1:0]];

    resp_has_request: assert property (@(posedge clk) disable iff (!reset_n)
        imem.resp_valid |-> !pc_fifo_empty);

endmodule

// File: tb/tb_vscale_imem_fetch_unit.sv
// Directed bench for vscale_imem_fetch_unit with an in-order instruction memory model whose
// responses can be held back; each task checks one scenario against hand-computed values.
module tb_vscale_imem_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_pif;
    logic        redirect;
    logic [31:0] pc_if;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_dx;
    logic [31:0] inst_pc;
    logic        inst_fault;

    logic [31:0] redirect_target;
    logic        mem_hold;
    logic [31:0] err_addr;
    int          accept_cnt;
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] pend_q[$];

    always #5 clk = ~clk;

    vscale_imem_fetch_unit_if #(.XPR_LEN(32), .INST_WIDTH(32)) imem ();

    // PC mux: sequential PC+4 unless the bench steers a redirect.
    assign pc_pif = redirect ? redirect_target : pc_if + 32'd4;

    vscale_imem_fetch_unit #(
        .XPR_LEN(32), .INST_WIDTH(32), .RESET_PC(32'h200), .DEPTH(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .PC_PIF     (pc_pif),
        .redirect   (redirect),
        .PC_IF      (pc_if),
        .imem       (imem),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_DX    (inst_dx),
        .inst_PC    (inst_pc),
        .inst_fault (inst_fault)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: responds in order, earliest the cycle after acceptance, unless held.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q.delete();
            imem.resp_valid <= 1'b0;
            imem.resp_data  <= '0;
            imem.resp_err   <= 1'b0;
            accept_cnt      <= 0;
        end else begin
            if (imem.req_valid && imem.req_ready) begin
                pend_q.push_back(imem.req_addr);
                accept_cnt <= accept_cnt + 1;
                $display("[%0t] req accepted addr=%h", $time, imem.req_addr);
            end
            if (!mem_hold && pend_q.size() > 0) begin
                imem.resp_valid <= 1'b1;
                imem.resp_data  <= data_of(pend_q[0]);
                imem.resp_err   <= (pend_q[0] == err_addr);
                void'(pend_q.pop_front());
            end else begin
                imem.resp_valid <= 1'b0;
            end
        end
    end

    // Leaves the bench 1ns into cycle c0, the first cycle after reset release.
    task automatic do_reset();
        @(negedge clk);
        reset_n         = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        inst_ready      = 1'b1;
        mem_hold        = 1'b0;
        err_addr        = 32'hFFFF_FFFF;
        imem.req_ready  = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        inst_ready      = 1'b1;
        mem_hold        = 1'b0;
        err_addr        = 32'hFFFF_FFFF;
        imem.req_ready  = 1'b1;
        @(negedge clk);
        #1;
        total_cnt++; if (imem.req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", imem.req_valid); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); else pass_cnt++;
        total_cnt++; if (pc_if !== 32'h200) $display("FAIL rst_pc_if: got %h expected 00000200", pc_if); else pass_cnt++;
        total_cnt++; if (inst_dx !== 32'h0) $display("FAIL rst_inst_dx: got %h expected 0", inst_dx); else pass_cnt++;
        total_cnt++; if (inst_pc !== 32'h0) $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); else pass_cnt++;
        total_cnt++; if (inst_fault !== 1'b0) $display("FAIL rst_inst_fault: got %b expected 0", inst_fault); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total_cnt++; if (imem.req_valid !== 1'b1) $display("FAIL rst_release_req_valid: got %b expected 1", imem.req_valid); else pass_cnt++;
        total_cnt++; if (imem.req_addr !== 32'h200) $display("FAIL rst_release_addr: got %h expected 00000200", imem.req_addr); else pass_cnt++;
    endtask

    task automatic test_stream();
        do_reset();
        total_cnt++; if (imem.req_addr !== 32'h200) $display("FAIL stream_c0_addr: got %h expected 00000200", imem.req_addr); else pass_cnt++;
        step();
        total_cnt++; if (imem.req_addr !== 32'h204) $display("FAIL stream_c1_addr: got %h expected 00000204", imem.req_addr); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL stream_c1_no_bypass: got %b expected 0", inst_valid); else pass_cnt++;
        step();
        total_cnt++; if (imem.req_addr !== 32'h208 || imem.req_valid !== 1'b1) $display("FAIL stream_c2_req: got %h/%b expected 00000208/1", imem.req_addr, imem.req_valid); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) $display("FAIL stream_c2_head: got %b/%h expected 1/00000200", inst_valid, inst_pc); else pass_cnt++;
        total_cnt++; if (inst_dx !== 32'hC0DE_0200) $display("FAIL stream_c2_data: got %h expected c0de0200", inst_dx); else pass_cnt++;
        step();
        total_cnt++; if (inst_pc !== 32'h204 || inst_dx !== 32'hC0DE_0204) $display("FAIL stream_c3_head: got %h/%h expected 00000204/c0de0204", inst_pc, inst_dx); else pass_cnt++;
        step();
        total_cnt++; if (inst_pc !== 32'h208) $display("FAIL stream_c4_head: got %h expected 00000208", inst_pc); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        do_reset();
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            exp_pc = 32'h200 + 32'(4 * i);
            total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc) $display("FAIL b2b_%0d: got %b/%h expected 1/%h", i, inst_valid, inst_pc, exp_pc); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        inst_ready = 1'b0;
        step();
        for (int c = 2; c <= 4; c++) begin
            step();
            total_cnt++; if (imem.req_valid !== 1'b0) $display("FAIL bp_full_c%0d: req_valid got %b expected 0", c, imem.req_valid); else pass_cnt++;
        end
        total_cnt++; if (accept_cnt !== 2) $display("FAIL bp_accepts: got %0d expected 2", accept_cnt); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) $display("FAIL bp_held_head: got %b/%h expected 1/00000200", inst_valid, inst_pc); else pass_cnt++;
        @(negedge clk);
        inst_ready = 1'b1;
        #1;
        total_cnt++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h208) $display("FAIL bp_resume_req: got %b/%h expected 1/00000208", imem.req_valid, imem.req_addr); else pass_cnt++;
        step();
        total_cnt++; if (inst_pc !== 32'h204) $display("FAIL bp_resume_c6: got %h expected 00000204", inst_pc); else pass_cnt++;
        step();
        total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h208 || inst_dx !== 32'hC0DE_0208) $display("FAIL bp_resume_c7: got %b/%h/%h expected 1/00000208/c0de0208", inst_valid, inst_pc, inst_dx); else pass_cnt++;
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        mem_hold = 1'b1;
        step();
        total_cnt++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h204) $display("FAIL rdi_c1_req: got %b/%h expected 1/00000204", imem.req_valid, imem.req_addr); else pass_cnt++;
        @(negedge clk);
        redirect        = 1'b1;
        redirect_target = 32'h400;
        #1;
        total_cnt++; if (imem.req_valid !== 1'b0) $display("FAIL rdi_c2_req_valid: got %b expected 0", imem.req_valid); else pass_cnt++;
        @(negedge clk);
        redirect = 1'b0;
        mem_hold = 1'b0;
        #1;
        total_cnt++; if (pc_if !== 32'h400) $display("FAIL rdi_c3_pc_if: got %h expected 00000400", pc_if); else pass_cnt++;
        total_cnt++; if (dut.kill_cnt_reg !== 2'd2) $display("FAIL rdi_c3_kill: got %0d expected 2", dut.kill_cnt_reg); else pass_cnt++;
        step();
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL rdi_c4_drop: got %b expected 0", inst_valid); else pass_cnt++;
        step();
        total_cnt++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h400 || inst_valid !== 1'b0) $display("FAIL rdi_c5: got %b/%h/%b expected 1/00000400/0", imem.req_valid, imem.req_addr, inst_valid); else pass_cnt++;
        step();
        total_cnt++; if (inst_valid !== 1'b0 || dut.kill_cnt_reg !== 2'd0) $display("FAIL rdi_c6: got %b/%0d expected 0/0", inst_valid, dut.kill_cnt_reg); else pass_cnt++;
        step();
        total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h400 || inst_dx !== 32'hC0DE_0400) $display("FAIL rdi_c7_head: got %b/%h/%h expected 1/00000400/c0de0400", inst_valid, inst_pc, inst_dx); else pass_cnt++;
    endtask

    task automatic test_redirect_with_resp_pop();
        do_reset();
        step();
        @(negedge clk);
        redirect        = 1'b1;
        redirect_target = 32'h600;
        #1;
        total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || imem.resp_valid !== 1'b1) $display("FAIL rdr_c2_setup: got %b/%h/%b expected 1/00000200/1", inst_valid, inst_pc, imem.resp_valid); else pass_cnt++;
        total_cnt++; if (imem.req_valid !== 1'b0) $display("FAIL rdr_c2_req_valid: got %b expected 0", imem.req_valid); else pass_cnt++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL rdr_c3_flush: got %b expected 0", inst_valid); else pass_cnt++;
        total_cnt++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h600) $display("FAIL rdr_c3_req: got %b/%h expected 1/00000600", imem.req_valid, imem.req_addr); else pass_cnt++;
        total_cnt++; if (dut.kill_cnt_reg !== 2'd0) $display("FAIL rdr_c3_kill: got %0d expected 0", dut.kill_cnt_reg); else pass_cnt++;
        step();
        step();
        total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h600) $display("FAIL rdr_c5_head: got %b/%h expected 1/00000600", inst_valid, inst_pc); else pass_cnt++;
    endtask

    task automatic test_fault();
        do_reset();
        err_addr = 32'h208;
        step();
        step();
        total_cnt++; if (inst_pc !== 32'h200 || inst_fault !== 1'b0) $display("FAIL flt_c2: got %h/%b expected 00000200/0", inst_pc, inst_fault); else pass_cnt++;
        step();
        total_cnt++; if (inst_pc !== 32'h204 || inst_fault !== 1'b0) $display("FAIL flt_c3: got %h/%b expected 00000204/0", inst_pc, inst_fault); else pass_cnt++;
        step();
        total_cnt++; if (inst_pc !== 32'h208 || inst_fault !== 1'b1 || inst_dx !== 32'hC0DE_0208) $display("FAIL flt_c4: got %h/%b/%h expected 00000208/1/c0de0208", inst_pc, inst_fault, inst_dx); else pass_cnt++;
        step();
        total_cnt++; if (inst_pc !== 32'h20C || inst_fault !== 1'b0) $display("FAIL flt_c5: got %h/%b expected 0000020c/0", inst_pc, inst_fault); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        inst_ready = 1'b0;
        repeat (4) step();
        total_cnt++; if (inst_valid !== 1'b1 || imem.req_valid !== 1'b0) $display("FAIL ar_full: got %b/%b expected 1/0", inst_valid, imem.req_valid); else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (inst_valid !== 1'b0 || imem.req_valid !== 1'b0) $display("FAIL ar_valids: got %b/%b expected 0/0", inst_valid, imem.req_valid); else pass_cnt++;
        total_cnt++; if (pc_if !== 32'h200) $display("FAIL ar_pc_if: got %h expected 00000200", pc_if); else pass_cnt++;
        total_cnt++; if (inst_pc !== 32'h0 || inst_dx !== 32'h0 || inst_fault !== 1'b0) $display("FAIL ar_head: got %h/%h/%b expected 0/0/0", inst_pc, inst_dx, inst_fault); else pass_cnt++;
        @(negedge clk);
        reset_n    = 1'b1;
        inst_ready = 1'b1;
        #1;
        total_cnt++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h200) $display("FAIL ar_first_req: got %b/%h expected 1/00000200", imem.req_valid, imem.req_addr); else pass_cnt++;
        step();
        total_cnt++; if (imem.req_addr !== 32'h204) $display("FAIL ar_second_req: got %h expected 00000204", imem.req_addr); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_with_resp_pop();
        test_fault();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
